// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the bit-phase state names used by uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling; define UART_RX_PARITY_EN to expect an even-parity
// bit between data bit 7 and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e   state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_s;

`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Counting restarts at mid start bit, so every later CNT_LAST hit lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                    par_bad <= 1'b0;
`endif
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt         <= '0;
                        shreg[bit_idx]  <= rx_s;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        par_bad <= (rx_s != ^shreg);
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end
`else
                            data  <= shreg;
                            valid <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                // A low stop bit means a break or line fault; wait for the line to recover.
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; frames are bit-banged on rx and results compared
// against an event queue built from the framing rules. Honours UART_RX_PARITY_EN like the design.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int         asserts = 0;
    int         failures = 0;
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;
    logic       mon_any;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        asserts++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    // Result events: kind 1 = valid with data, 2 = framing error, 3 = parity error.
    always @(negedge clk) begin
        mon_any = valid | frame_err | parity_err;
        if (mon_any) begin
            checkOutput("one_hot", 32'(valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
            checkOutput("pulse_width", 32'(prev_pulse), 32'd0);
            if (!frame_err) checkOutput("busy_at_result", 32'(busy), 32'd0);
            if (valid)          obs_q.push_back({2'd1, data});
            else if (frame_err) obs_q.push_back({2'd2, 8'h00});
            else                obs_q.push_back({2'd3, 8'h00});
        end
        prev_pulse = mon_any;
    end

    function automatic void modelFrame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
        if (!stop_ok)                 exp_q.push_back({2'd2, 8'h00});
        else if (PAR_EN && par_flip)  exp_q.push_back({2'd3, 8'h00});
        else begin
            exp_q.push_back({2'd1, b});
            last_good = b;
        end
    endfunction

    task automatic driveBit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // A low stop bit is held for three bit times and rx is left low for the caller to release.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input bit par_flip, input int abort_bit);
        driveBit(1'b0);
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                rx = b[i];
                repeat (CPB / 2) @(negedge clk);
                checkOutput("busy_mid_frame", 32'(busy), 32'd1);
                rst_n = 1'b0;
                rx    = 1'b1;
                return;
            end
            driveBit(b[i]);
        end
        if (PAR_EN) driveBit((^b) ^ par_flip);
        if (stop_ok) begin
            driveBit(1'b1);
        end else begin
            repeat (3) driveBit(1'b0);
        end
        modelFrame(b, stop_ok, par_flip);
    endtask

    task automatic compareResults(input string tag);
        repeat (2 * CPB) @(negedge clk);
        checkOutput({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            checkOutput({tag, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
        checkOutput({tag, "_data"}, 32'(data), 32'(last_good));
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bit         stop_ok;
        bit         par_flip;
        int         gap;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_data", 32'(data), 32'h00);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_parity_err", 32'(parity_err), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        applyStimulus(8'hA5, 1'b1, 1'b0, -1);
        compareResults("single");

        applyStimulus(8'hA5, 1'b1, 1'b0, -1);
        applyStimulus(8'h3C, 1'b1, 1'b0, -1);
        compareResults("b2b");

        rx = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("glitch_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("glitch_busy_drop", 32'(busy), 32'd0);
        compareResults("glitch");

        applyStimulus(8'h3C, 1'b0, 1'b0, -1);
        checkOutput("ferr_busy_held", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("ferr_busy_drop", 32'(busy), 32'd0);
        compareResults("frame_err");

        applyStimulus(8'hA5, 1'b1, 1'b0, 4);
        @(negedge clk);
        last_good = 8'h00;
        checkOutput("abort_data", 32'(data), 32'h00);
        checkOutput("abort_valid", 32'(valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_frame_err", 32'(frame_err), 32'd0);
        checkOutput("abort_parity_err", 32'(parity_err), 32'd0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        applyStimulus(8'h5A, 1'b1, 1'b0, -1);
        compareResults("after_reset");

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'hA5, 1'b1, 1'b0, -1);
        applyStimulus(8'hA5, 1'b1, 1'b1, -1);
        compareResults("parity");
`endif

        for (int n = 0; n < 16; n++) begin
            b        = 8'($urandom);
            stop_ok  = ($urandom_range(7) != 0);
            par_flip = PAR_EN && ($urandom_range(3) == 0);
            gap      = int'($urandom_range(2));
            applyStimulus(b, stop_ok, par_flip, -1);
            if (!stop_ok) begin
                rx  = 1'b1;
                gap = gap + 1;
            end
            repeat (gap * CPB) @(negedge clk);
        end
        compareResults("random");

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, 8N1 framing (optional even parity), LSB first, fixed baud set by a clock-divide parameter. It is the receive counterpart of `uart_tx` and shares its bit timing, so a `uart_tx` output looped into `rx` delivers every byte unchanged. It sits between the asynchronous serial pin and on-chip logic: it presents each received byte with a one-cycle `valid` strobe and flags framing and parity errors.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; must be ≥ 4 and even.
- `clk` input 1, single system clock; all logic on the rising edge.
- `rst_n` input 1, asynchronous active-low reset.
- `rx` input 1, serial line, asynchronous to `clk`, idles high.
- `data` output 8, last correctly received byte; held until the next good byte.
- `valid` output 1, one-cycle pulse when `data` has just been updated.
- `busy` output 1, high from start-bit detection until the FSM returns to IDLE.
- `frame_err` output 1, one-cycle pulse when the stop bit samples low.
- `parity_err` output 1, one-cycle pulse on parity mismatch; tied 0 without `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1); the FSM sees only `rx_s`.
- Counters: `clk_cnt` runs 0..CLKS_PER_BIT-1; `bit_idx` runs 0..7.
- IDLE: if `rx_s`==0, go to START with `clk_cnt`=0 and `busy`=1.
- START: at `clk_cnt`==CLKS_PER_BIT/2-1 (mid start bit), sample `rx_s`.
  - Low: go to DATA with `clk_cnt`=0.
  - High: treat as a glitch; return to IDLE with no pulse.
- DATA: at `clk_cnt`==CLKS_PER_BIT-1, shift `rx_s` into `shreg[bit_idx]` (LSB first) and reset `clk_cnt`. After bit 7, go to PARITY (if enabled) or STOP.
- PARITY: at `clk_cnt`==CLKS_PER_BIT-1, compare `rx_s` with the XOR of `shreg` (even parity). Record any mismatch, then go to STOP.
- STOP: at `clk_cnt`==CLKS_PER_BIT-1, sample `rx_s`.
  - High, no parity mismatch: `data`<=`shreg`, `valid` pulse; go to IDLE.
  - High, parity mismatch: `parity_err` pulse, `data` unchanged, no `valid`; go to IDLE.
  - Low: `frame_err` pulse, `data` unchanged, no `valid`; go to WAIT_IDLE.
- WAIT_IDLE: hold `busy` until `rx_s`==1 (break or line fault), then go to IDLE. No further pulses while waiting.
- All samples are taken at mid-bit. The return to IDLE happens halfway through the stop bit, so a back-to-back start bit is never missed.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `busy`=0, `frame_err`=0, `parity_err`=0, FSM=IDLE, counters=0.
- Asserting `rst_n` mid-frame immediately aborts the frame and produces no pulse. After release, the receiver waits for a fresh falling edge in IDLE.
- Detection latency: 2 `clk` cycles from the `rx` edge to `rx_s` (synchronizer), plus 1 cycle to enter START.
- Result latency: `valid`, `frame_err` and `parity_err` assert the cycle after the stop-bit sample edge. That is about 9.5 bit times after the start edge (10.5 with parity), plus 3 cycles.
- `valid`, `frame_err` and `parity_err` are mutually exclusive and each lasts exactly 1 cycle.
- `busy` drops in the same cycle that the result pulse asserts (the FSM is back in IDLE).
- No backpressure: a consumer that misses the `valid` pulse loses the byte, because `data` is overwritten by the next good byte.

## Configuration
- `UART_RX_PARITY_EN` defined: a PARITY state expects one even-parity bit between bit 7 and stop, and `parity_err` is live.
- Not defined: no PARITY state, the frame is 10 bits, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg`:
  - constant `UART_DATA_BITS`=8;
  - FSM state enum IDLE/START/DATA/PARITY/STOP/WAIT_IDLE, shared with `uart_tx` for its bit-phase naming.
- Sub-module `uart_rx_sync`: a 2-flop synchronizer with async active-low reset to 1. It is used once, on `rx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and a 10 ns clock.
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> exactly one `valid`, `data`=8'hA5, `busy` high for the frame and low with `valid`, no error pulses.
- 0xA5 then 0x3C back-to-back (the next start immediately after a 1-bit stop) -> two `valid` pulses, with `data` reading A5 and then 3C.
- `rx` low for 4 cycles then high -> START aborts at the mid-bit sample; no pulse; `busy` returns to 0 within 8 cycles.
- Frame 0x3C with the stop bit driven low, line held low for 3 bit times -> one `frame_err`, no `valid`, `data` keeps its previous value, `busy` stays high until `rx` rises.
- `rst_n` pulsed low during data bit 4 of 0xA5 -> all outputs return to reset values and no pulse occurs; a following 0x5A frame is received correctly.
- With `UART_RX_PARITY_EN`: 0xA5 with parity 0 -> `valid`; 0xA5 with parity 1 -> `parity_err`, no `valid`.
